// File: rtl/csr_ex_sequencer.sv
// -----------------------------------------------------------------------------
// csr_ex_sequencer
//
// Serialises CSR side effects for the WB stage. Three kinds of work share a
// single CSR write port:
//   * exception / interrupt entry: PRMD <- CRMD[2:0], CRMD[2:0] <- 0,
//     ESTAT[30:16] <- {esubcode, ecode}, ERA <- pc, then a flush to EENTRY
//   * ertn: CRMD[2:0] <- PRMD[2:0], then a flush to ERA
//   * csrrd/csrwr/csrxchg: single-cycle read-modify-write in the grant cycle
//
// Optional feature macro: CSR_SEQ_INT_EN
//   defined   -> has_int is accepted as an event (ecode 0, esubcode 0)
//   undefined -> has_int is ignored
//
// Ports
//   clk, resetn                 clock, asynchronous active-low reset
//   inst_req_valid/inst_we/inst_num/inst_wvalue/inst_wmask
//                               CSR instruction request from WB
//   inst_req_ready, inst_rvalue grant strobe and pre-write CSR value
//   ex_valid, wb_pc, ex_ecode, ex_esubcode, ertn_valid, has_int
//                               pipeline events
//   seq_busy                    stall request to the pipeline
//   flush, flush_target         one-cycle redirect pulse and its target
//   csr_wnum/csr_we/csr_wvalue/csr_wmask
//                               CSR file write port (masked write at clock edge)
//   csr_rnum, csr_rvalue        CSR file combinational read port
// -----------------------------------------------------------------------------
module csr_ex_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req_valid,
  input  logic        inst_we,
  input  logic [13:0] inst_num,
  input  logic [31:0] inst_wvalue,
  input  logic [31:0] inst_wmask,
  output logic        inst_req_ready,
  output logic [31:0] inst_rvalue,
  input  logic        ex_valid,
  input  logic [31:0] wb_pc,
  input  logic [5:0]  ex_ecode,
  input  logic [8:0]  ex_esubcode,
  input  logic        ertn_valid,
  input  logic        has_int,
  output logic        seq_busy,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic [13:0] csr_wnum,
  output logic        csr_we,
  output logic [31:0] csr_wvalue,
  output logic [31:0] csr_wmask,
  output logic [13:0] csr_rnum,
  input  logic [31:0] csr_rvalue
);

  typedef enum logic [2:0] {
    IDLE,
    E_PRMD,
    E_CRMD,
    E_ESTAT,
    E_ERA,
    E_JUMP,
    R_CRMD,
    R_JUMP
  } state_t;

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_EENTRY = 14'hC;

  state_t      state;
  state_t      next_state;
  logic [31:0] saved_pc;
  logic [5:0]  saved_ecode;
  logic [8:0]  saved_esubcode;
  logic        int_event;
  logic        trap_event;

  // Interrupts share the exception entry path; without the feature the
  // has_int input is tied off so only real exceptions start an entry.
`ifdef CSR_SEQ_INT_EN
  assign int_event = has_int;
`else
  logic unused_has_int;
  assign unused_has_int = has_int;
  assign int_event      = 1'b0;
`endif

  assign trap_event = ex_valid | int_event;

  // State register plus the exception context captured at acceptance. An
  // interrupt without a simultaneous exception records ecode/esubcode 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state          <= IDLE;
      saved_pc       <= '0;
      saved_ecode    <= '0;
      saved_esubcode <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && trap_event) begin
        saved_pc       <= wb_pc;
        saved_ecode    <= ex_valid ? ex_ecode : 6'h0;
        saved_esubcode <= ex_valid ? ex_esubcode : 9'h0;
      end
    end
  end

  // Next-state and output decode. Everything defaults to zero so that an
  // idle cycle, a jump cycle, or reset drive a quiet CSR port. Outputs are
  // also forced low while resetn is asserted, independent of the inputs.
  always_comb begin
    next_state     = state;
    inst_req_ready = 1'b0;
    inst_rvalue    = 32'h0;
    seq_busy       = 1'b0;
    flush          = 1'b0;
    flush_target   = 32'h0;
    csr_we         = 1'b0;
    csr_wnum       = 14'h0;
    csr_wvalue     = 32'h0;
    csr_wmask      = 32'h0;
    csr_rnum       = 14'h0;

    if (resetn) begin
      case (state)
        IDLE: begin
          if (trap_event) begin
            seq_busy   = 1'b1;
            next_state = E_PRMD;
          end else if (ertn_valid) begin
            seq_busy   = 1'b1;
            next_state = R_CRMD;
          end else if (inst_req_valid) begin
            // The read returns the value before this cycle's write lands.
            inst_req_ready = 1'b1;
            csr_rnum       = inst_num;
            inst_rvalue    = csr_rvalue;
            if (inst_we) begin
              csr_we     = 1'b1;
              csr_wnum   = inst_num;
              csr_wvalue = inst_wvalue;
              csr_wmask  = inst_wmask;
            end
          end
        end
        E_PRMD: begin
          seq_busy   = 1'b1;
          csr_rnum   = CSR_CRMD;
          csr_we     = 1'b1;
          csr_wnum   = CSR_PRMD;
          csr_wvalue = {29'h0, csr_rvalue[2:0]};
          csr_wmask  = 32'h0000_0007;
          next_state = E_CRMD;
        end
        E_CRMD: begin
          seq_busy   = 1'b1;
          csr_we     = 1'b1;
          csr_wnum   = CSR_CRMD;
          csr_wvalue = 32'h0;
          csr_wmask  = 32'h0000_0007;
          next_state = E_ESTAT;
        end
        E_ESTAT: begin
          seq_busy   = 1'b1;
          csr_we     = 1'b1;
          csr_wnum   = CSR_ESTAT;
          csr_wvalue = {1'b0, saved_esubcode, saved_ecode, 16'h0};
          csr_wmask  = 32'h7FFF_0000;
          next_state = E_ERA;
        end
        E_ERA: begin
          seq_busy   = 1'b1;
          csr_we     = 1'b1;
          csr_wnum   = CSR_ERA;
          csr_wvalue = saved_pc;
          csr_wmask  = 32'hFFFF_FFFF;
          next_state = E_JUMP;
        end
        E_JUMP: begin
          seq_busy     = 1'b1;
          csr_rnum     = CSR_EENTRY;
          flush        = 1'b1;
          flush_target = csr_rvalue;
          next_state   = IDLE;
        end
        R_CRMD: begin
          seq_busy   = 1'b1;
          csr_rnum   = CSR_PRMD;
          csr_we     = 1'b1;
          csr_wnum   = CSR_CRMD;
          csr_wvalue = {29'h0, csr_rvalue[2:0]};
          csr_wmask  = 32'h0000_0007;
          next_state = R_JUMP;
        end
        R_JUMP: begin
          seq_busy     = 1'b1;
          csr_rnum     = CSR_ERA;
          flush        = 1'b1;
          flush_target = csr_rvalue;
          next_state   = IDLE;
        end
        default: next_state = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_ex_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_ex_sequencer
//
// Drives csr_ex_sequencer against a behavioural CSR file (csr_mem) and checks
// every cycle's outputs. Inputs change just after the falling edge, outputs
// are sampled 1 time unit later, and the DUT's requested CSR write is applied
// to csr_mem at the following rising edge.
// -----------------------------------------------------------------------------
module tb_csr_ex_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req_valid, inst_we;
  logic [13:0] inst_num;
  logic [31:0] inst_wvalue, inst_wmask;
  logic        inst_req_ready;
  logic [31:0] inst_rvalue;
  logic        ex_valid;
  logic [31:0] wb_pc;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic        ertn_valid, has_int;
  logic        seq_busy, flush;
  logic [31:0] flush_target;
  logic [13:0] csr_wnum, csr_rnum;
  logic        csr_we;
  logic [31:0] csr_wvalue, csr_wmask, csr_rvalue;

  logic [31:0] csr_mem [0:16383];

  always #5 clk = ~clk;

  assign csr_rvalue = csr_mem[csr_rnum];

  csr_ex_sequencer dut (
    .clk(clk), .resetn(resetn),
    .inst_req_valid(inst_req_valid), .inst_we(inst_we), .inst_num(inst_num),
    .inst_wvalue(inst_wvalue), .inst_wmask(inst_wmask),
    .inst_req_ready(inst_req_ready), .inst_rvalue(inst_rvalue),
    .ex_valid(ex_valid), .wb_pc(wb_pc), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
    .ertn_valid(ertn_valid), .has_int(has_int),
    .seq_busy(seq_busy), .flush(flush), .flush_target(flush_target),
    .csr_wnum(csr_wnum), .csr_we(csr_we), .csr_wvalue(csr_wvalue), .csr_wmask(csr_wmask),
    .csr_rnum(csr_rnum), .csr_rvalue(csr_rvalue)
  );

  typedef struct packed {
    logic        busy;
    logic        flush;
    logic [31:0] target;
    logic        ready;
    logic [31:0] rvalue;
    logic        we;
    logic [13:0] wnum;
    logic [31:0] wvalue;
    logic [31:0] wmask;
    logic [13:0] rnum;
  } obs_t;

  typedef struct packed {
    logic        inst_req_valid;
    logic        inst_we;
    logic [13:0] inst_num;
    logic [31:0] inst_wvalue;
    logic [31:0] inst_wmask;
    logic        ex_valid;
    logic [31:0] wb_pc;
    logic [5:0]  ecode;
    logic [8:0]  esub;
    logic        ertn_valid;
    logic        has_int;
  } stim_t;

  typedef struct {
    string name;
    stim_t stim;
    obs_t  exp;
  } vec_t;

  int   n_cmp  = 0;
  int   n_fail = 0;
  obs_t pend[$];

  // Deterministic CSR contents so table entries can quote read values.
  task automatic init_csr();
    for (int i = 0; i < 16384; i++) csr_mem[i] = 32'hC5A0_0000 ^ 32'(i);
  endtask

  function automatic stim_t s_none();
    stim_t s = '0;
    return s;
  endfunction

  function automatic stim_t s_inst(input logic we, input logic [13:0] num,
                                   input logic [31:0] wv, input logic [31:0] wm);
    stim_t s = '0;
    s.inst_req_valid = 1'b1; s.inst_we = we; s.inst_num = num;
    s.inst_wvalue = wv; s.inst_wmask = wm;
    return s;
  endfunction

  function automatic obs_t o_busy();
    obs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_write(input logic [13:0] rn, input logic [13:0] wn,
                                   input logic [31:0] v, input logic [31:0] m);
    obs_t o = '0;
    o.busy = 1'b1; o.rnum = rn; o.we = 1'b1; o.wnum = wn; o.wvalue = v; o.wmask = m;
    return o;
  endfunction

  function automatic obs_t o_flush(input logic [13:0] rn, input logic [31:0] t);
    obs_t o = '0;
    o.busy = 1'b1; o.flush = 1'b1; o.target = t; o.rnum = rn;
    return o;
  endfunction

  function automatic obs_t o_grant(input logic [13:0] num, input logic we,
                                   input logic [31:0] wv, input logic [31:0] wm,
                                   input logic [31:0] rv);
    obs_t o = '0;
    o.ready = 1'b1; o.rnum = num; o.rvalue = rv;
    if (we) begin
      o.we = 1'b1; o.wnum = num; o.wvalue = wv; o.wmask = wm;
    end
    return o;
  endfunction

  function automatic obs_t sample_dut();
    obs_t o;
    o.busy = seq_busy; o.flush = flush; o.target = flush_target;
    o.ready = inst_req_ready; o.rvalue = inst_rvalue;
    o.we = csr_we; o.wnum = csr_wnum; o.wvalue = csr_wvalue; o.wmask = csr_wmask;
    o.rnum = csr_rnum;
    return o;
  endfunction

  task automatic applyStimulus(input stim_t s);
    inst_req_valid = s.inst_req_valid; inst_we = s.inst_we; inst_num = s.inst_num;
    inst_wvalue = s.inst_wvalue; inst_wmask = s.inst_wmask;
    ex_valid = s.ex_valid; wb_pc = s.wb_pc; ex_ecode = s.ecode; ex_esubcode = s.esub;
    ertn_valid = s.ertn_valid; has_int = s.has_int;
  endtask

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t act = sample_dut();
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got busy=%b flush=%b tgt=%h rdy=%b rv=%h we=%b wn=%h wv=%h wm=%h rn=%h | want busy=%b flush=%b tgt=%h rdy=%b rv=%h we=%b wn=%h wv=%h wm=%h rn=%h",
               name, act.busy, act.flush, act.target, act.ready, act.rvalue, act.we,
               act.wnum, act.wvalue, act.wmask, act.rnum,
               exp.busy, exp.flush, exp.target, exp.ready, exp.rvalue, exp.we,
               exp.wnum, exp.wvalue, exp.wmask, exp.rnum);
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // One full cycle: drive, check, then let the CSR file take the DUT's write.
  task automatic runCycle(input string name, input stim_t s, input obs_t exp);
    logic        we_c;
    logic [13:0] wn_c;
    logic [31:0] wv_c, wm_c;
    applyStimulus(s);
    #1;
    checkOutput(name, exp);
    we_c = csr_we; wn_c = csr_wnum; wv_c = csr_wvalue; wm_c = csr_wmask;
    @(posedge clk);
    if (we_c) csr_mem[wn_c] = (csr_mem[wn_c] & ~wm_c) | (wv_c & wm_c);
    @(negedge clk);
  endtask

  task automatic doReset();
    resetn = 1'b0;
    applyStimulus(s_none());
    @(negedge clk);
    resetn = 1'b1;
    pend.delete();
    init_csr();
  endtask

  // Reference model: on acceptance, the whole expected sequence is expanded
  // from the architectural rules using the CSR contents at that moment.
  task automatic modelStep(input stim_t s, output obs_t exp);
    logic       int_ev;
    logic [5:0] ec;
    logic [8:0] es;
`ifdef CSR_SEQ_INT_EN
    int_ev = s.has_int;
`else
    int_ev = 1'b0;
`endif
    if (pend.size() > 0) begin
      exp = pend.pop_front();
    end else if (s.ex_valid || int_ev) begin
      ec  = s.ex_valid ? s.ecode : 6'h0;
      es  = s.ex_valid ? s.esub : 9'h0;
      exp = o_busy();
      pend.push_back(o_write(14'h0, 14'h1, {29'h0, csr_mem[0][2:0]}, 32'h7));
      pend.push_back(o_write(14'h0, 14'h0, 32'h0, 32'h7));
      pend.push_back(o_write(14'h0, 14'h5, {1'b0, es, ec, 16'h0}, 32'h7FFF_0000));
      pend.push_back(o_write(14'h0, 14'h6, s.wb_pc, 32'hFFFF_FFFF));
      pend.push_back(o_flush(14'hC, csr_mem[12]));
    end else if (s.ertn_valid) begin
      exp = o_busy();
      pend.push_back(o_write(14'h1, 14'h0, {29'h0, csr_mem[1][2:0]}, 32'h7));
      pend.push_back(o_flush(14'h6, csr_mem[6]));
    end else if (s.inst_req_valid) begin
      exp = o_grant(s.inst_num, s.inst_we, s.inst_wvalue, s.inst_wmask, csr_mem[s.inst_num]);
    end else begin
      exp = '0;
    end
  endtask

  vec_t        tbl [8];
  stim_t       s, junk;
  obs_t        e;
  logic [13:0] nums [8];

  initial begin
    // Single-cycle behaviour from a fresh IDLE state.
    tbl[0] = '{"idle_quiet", s_none(), '0};
    tbl[1] = '{"inst_read", s_inst(1'b0, 14'h30, 32'hFFFF_FFFF, 32'hFFFF_FFFF),
               o_grant(14'h30, 1'b0, 32'h0, 32'h0, 32'hC5A0_0030)};
    tbl[2] = '{"inst_write", s_inst(1'b1, 14'h31, 32'hDEAD_BEEF, 32'h0000_FFFF),
               o_grant(14'h31, 1'b1, 32'hDEAD_BEEF, 32'h0000_FFFF, 32'hC5A0_0031)};
    s = s_inst(1'b1, 14'h30, 32'h1, 32'h1); s.ex_valid = 1'b1; s.wb_pc = 32'h100;
    tbl[3] = '{"ex_over_inst", s, o_busy()};
    s = s_inst(1'b1, 14'h30, 32'h1, 32'h1); s.ertn_valid = 1'b1;
    tbl[4] = '{"ertn_over_inst", s, o_busy()};
    s = s_none(); s.ex_valid = 1'b1; s.ertn_valid = 1'b1;
    tbl[5] = '{"ex_and_ertn", s, o_busy()};
    s = s_inst(1'b0, 14'h32, 32'h0, 32'h0); s.has_int = 1'b1;
`ifdef CSR_SEQ_INT_EN
    tbl[6] = '{"int_over_inst", s, o_busy()};
    s = s_none(); s.has_int = 1'b1;
    tbl[7] = '{"int_alone", s, o_busy()};
`else
    tbl[6] = '{"int_ignored_inst", s, o_grant(14'h32, 1'b0, 32'h0, 32'h0, 32'hC5A0_0032)};
    s = s_none(); s.has_int = 1'b1;
    tbl[7] = '{"int_alone_ignored", s, '0};
`endif

    // Outputs must stay low under reset even with every request active.
    init_csr();
    resetn = 1'b0;
    s = s_inst(1'b1, 14'h30, 32'h5, 32'hF); s.ertn_valid = 1'b1;
    runCycle("reset_outputs", s, '0);
    s.ex_valid = 1'b1;
    runCycle("reset_outputs_ex", s, '0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) begin
      doReset();
      runCycle(tbl[i].name, tbl[i].stim, tbl[i].exp);
    end

    // Exception entry: five cycles after acceptance, flush in the fifth.
    doReset();
    csr_mem[0] = 32'h3; csr_mem[12] = 32'h1C00_8000;
    s = s_none(); s.ex_valid = 1'b1; s.wb_pc = 32'h1C00_0040; s.ecode = 6'h0B;
    runCycle("ex_accept", s, o_busy());
    runCycle("ex_prmd", s_none(), o_write(14'h0, 14'h1, 32'h3, 32'h7));
    runCycle("ex_crmd", s_none(), o_write(14'h0, 14'h0, 32'h0, 32'h7));
    runCycle("ex_estat", s_none(), o_write(14'h0, 14'h5, 32'h000B_0000, 32'h7FFF_0000));
    runCycle("ex_era", s_none(), o_write(14'h0, 14'h6, 32'h1C00_0040, 32'hFFFF_FFFF));
    runCycle("ex_jump", s_none(), o_flush(14'hC, 32'h1C00_8000));
    runCycle("ex_after", s_none(), '0);
    checkValue("ex_prmd_val", {29'h0, csr_mem[1][2:0]}, 32'h3);
    checkValue("ex_crmd_val", {29'h0, csr_mem[0][2:0]}, 32'h0);
    checkValue("ex_estat_val", {17'h0, csr_mem[5][30:16]}, 32'h000B);
    checkValue("ex_era_val", csr_mem[6], 32'h1C00_0040);

    // ertn: CRMD restored next cycle, flush to ERA the cycle after.
    doReset();
    csr_mem[0] = 32'h0; csr_mem[1] = 32'h7; csr_mem[6] = 32'h1C00_0100;
    s = s_none(); s.ertn_valid = 1'b1;
    runCycle("ertn_accept", s, o_busy());
    runCycle("ertn_crmd", s_none(), o_write(14'h1, 14'h0, 32'h7, 32'h7));
    runCycle("ertn_jump", s_none(), o_flush(14'h6, 32'h1C00_0100));
    runCycle("ertn_after", s_none(), '0);
    checkValue("ertn_crmd_val", {29'h0, csr_mem[0][2:0]}, 32'h7);

    // csrxchg read-modify-write in the grant cycle.
    doReset();
    csr_mem[14'h30] = 32'h1234_5678;
    runCycle("xchg_grant", s_inst(1'b1, 14'h30, 32'hFFFF_0000, 32'h00FF_FF00),
             o_grant(14'h30, 1'b1, 32'hFFFF_0000, 32'h00FF_FF00, 32'h1234_5678));
    checkValue("xchg_save0", csr_mem[14'h30], 32'h12FF_0078);

    // Held instruction behind an exception, with noise on ignored inputs.
    doReset();
    csr_mem[0] = 32'h5; csr_mem[12] = 32'h1C00_2000;
    s = s_inst(1'b0, 14'h33, 32'h0, 32'h0);
    s.ex_valid = 1'b1; s.wb_pc = 32'h8000_0004; s.ecode = 6'h3F; s.esub = 9'h1FF;
    runCycle("hold_accept", s, o_busy());
    junk = s_inst(1'b0, 14'h33, 32'h0, 32'h0);
    junk.ex_valid = 1'b1; junk.ertn_valid = 1'b1; junk.has_int = 1'b1;
    junk.wb_pc = 32'h0BAD_0BAD; junk.ecode = 6'h01; junk.esub = 9'h002;
    runCycle("hold_prmd", junk, o_write(14'h0, 14'h1, 32'h5, 32'h7));
    runCycle("hold_crmd", junk, o_write(14'h0, 14'h0, 32'h0, 32'h7));
    runCycle("hold_estat", junk, o_write(14'h0, 14'h5, 32'h7FFF_0000, 32'h7FFF_0000));
    runCycle("hold_era", junk, o_write(14'h0, 14'h6, 32'h8000_0004, 32'hFFFF_FFFF));
    runCycle("hold_jump", junk, o_flush(14'hC, 32'h1C00_2000));
    runCycle("hold_grant", s_inst(1'b0, 14'h33, 32'h0, 32'h0),
             o_grant(14'h33, 1'b0, 32'h0, 32'h0, 32'hC5A0_0033));

    // Reset during ESTAT abandons the entry; next request is served at once.
    doReset();
    s = s_none(); s.ex_valid = 1'b1; s.wb_pc = 32'h1C00_0300; s.ecode = 6'h0A;
    runCycle("rst_accept", s, o_busy());
    runCycle("rst_prmd", s_none(), o_write(14'h0, 14'h1, {29'h0, 3'(32'hC5A0_0000)}, 32'h7));
    runCycle("rst_crmd", s_none(), o_write(14'h0, 14'h0, 32'h0, 32'h7));
    resetn = 1'b0;
    s = s_inst(1'b1, 14'h30, 32'hFFFF_FFFF, 32'hFFFF_FFFF); s.ex_valid = 1'b1;
    runCycle("rst_mid_estat", s, '0);
    runCycle("rst_hold", s, '0);
    resetn = 1'b1;
    runCycle("rst_resume_grant", s_inst(1'b0, 14'h31, 32'h0, 32'h0),
             o_grant(14'h31, 1'b0, 32'h0, 32'h0, 32'hC5A0_0031));
    runCycle("rst_quiet1", s_none(), '0);
    runCycle("rst_quiet2", s_none(), '0);
    checkValue("rst_estat_kept", csr_mem[5], 32'hC5A0_0005);
    checkValue("rst_era_kept", csr_mem[6], 32'hC5A0_0006);
    checkValue("rst_save0_kept", csr_mem[14'h30], 32'hC5A0_0030);

`ifdef CSR_SEQ_INT_EN
    // Interrupt alone enters with ecode/esubcode forced to zero.
    doReset();
    csr_mem[0] = 32'h4; csr_mem[5] = 32'hFFFF_FFFF; csr_mem[12] = 32'h1C00_4000;
    s = s_none(); s.has_int = 1'b1; s.wb_pc = 32'h1C00_0200; s.ecode = 6'h15; s.esub = 9'h7;
    runCycle("int_accept", s, o_busy());
    runCycle("int_prmd", s_none(), o_write(14'h0, 14'h1, 32'h4, 32'h7));
    runCycle("int_crmd", s_none(), o_write(14'h0, 14'h0, 32'h0, 32'h7));
    runCycle("int_estat", s_none(), o_write(14'h0, 14'h5, 32'h0, 32'h7FFF_0000));
    runCycle("int_era", s_none(), o_write(14'h0, 14'h6, 32'h1C00_0200, 32'hFFFF_FFFF));
    runCycle("int_jump", s_none(), o_flush(14'hC, 32'h1C00_4000));
    checkValue("int_estat_val", csr_mem[5], 32'h8000_FFFF);
`endif

    // Randomised traffic against the reference model.
    nums = '{14'h0, 14'h1, 14'h5, 14'h6, 14'hC, 14'h30, 14'h31, 14'h3FFF};
    doReset();
    for (int i = 0; i < 3000; i++) begin
      s = '0;
      s.ex_valid       = ($urandom_range(0, 7) == 0);
      s.ertn_valid     = ($urandom_range(0, 5) == 0);
      s.has_int        = ($urandom_range(0, 7) == 0);
      s.inst_req_valid = $urandom_range(0, 1) == 1;
      s.inst_we        = $urandom_range(0, 1) == 1;
      s.inst_num       = nums[$urandom_range(0, 7)];
      s.inst_wvalue    = $urandom;
      s.inst_wmask     = $urandom;
      s.wb_pc          = $urandom;
      s.ecode          = 6'($urandom);
      s.esub           = 9'($urandom);
      modelStep(s, e);
      runCycle("random", s, e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
